sseg_digit_scanner: RTL
=======================

SSEG_DIGIT_SCANNER -- requirements
Module: sseg_digit_scanner

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter SCAN_DIV, default 50000, SHALL set the clock cycles each digit is selected (range 4..2^20).
REQ-003 Parameter BLANK_CYC, default 16, SHALL set the cycles all anodes are off after each digit change (0..SCAN_DIV-2).
REQ-004 Clk  input  1  rising-edge clock.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Enable  input  1  1 = scanning runs; 0 = scan frozen, display dark.
REQ-007 Value  input  16  four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-008 DPIn  input  4  decimal point request per digit, bit i for digit i.
REQ-009 LZB  input  1  1 = leading-zero blanking on.
REQ-010 Hex  output  4  nibble for the currently selected digit, to the common-anode 7-segment decoder Hex input.
REQ-011 DP  output  1  decimal point for the selected digit, to the decoder DP input (1 = lit).
REQ-012 Anode  output  4  active-low digit enables, bit i drives digit i.
REQ-013 DigitSel  output  2  index of the currently selected digit.
REQ-014 Frame  output  1  one-cycle pulse at each frame boundary, when Value/DPIn are captured.

Function
REQ-015 A prescaler SHALL count 0..SCAN_DIV-1 while Enable=1; tick = (count == SCAN_DIV-1); count wraps to 0 on tick.
REQ-016 On tick, DigitSel SHALL advance 0->1->2->3->0, taking effect on the next cycle.
REQ-017 On a tick with DigitSel=3, Value and DPIn SHALL be captured into shadow registers and Frame SHALL be 1 for exactly that cycle.
REQ-018 Hex, DP and leading-zero decisions SHALL use only shadow registers, never Value/DPIn directly.
REQ-019 Hex SHALL equal shadow nibble DigitSel; DP SHALL equal shadow DP bit DigitSel.
REQ-020 Digit i SHALL be blanked when LZB=1, i>=1, shadow nibbles i..3 are all zero, and shadow DP bit i is 0; digit 0 SHALL never be blanked.
REQ-021 Anode[i] SHALL be 0 only when DigitSel=i, Enable=1, count>=BLANK_CYC, and digit i is not blanked; otherwise 1.
REQ-022 At most one Anode bit SHALL be 0 in any cycle.
REQ-023 Enable=0 SHALL hold count, DigitSel and shadows, force Anode=4'b1111 and Frame=0; on return to 1 counting SHALL resume from the held count.
REQ-024 All outputs SHALL come from registers or register-only logic; there SHALL be no combinational path from any input to any output.
REQ-025 Value/DPIn changes outside a Frame cycle SHALL have no effect on displayed digits until the next Frame.
REQ-026 LZB changes SHALL take effect in the next cycle.

Reset
REQ-027 While Reset=1 (sampled at Clk edge): count=0, DigitSel=0, shadow Value=16'h0000, shadow DP=4'b0000, Anode=4'b1111, Hex=4'h0, DP=0, Frame=0.
REQ-028 Reset SHALL override Enable and any tick in the same cycle.
REQ-029 First cycle after reset release SHALL begin the BLANK_CYC gap of digit 0, with count=0.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-030 Reset, Enable=1, Value=16'h1234, DPIn=0, LZB=0 -> first Frame at cycle 31 after release; next frame shows digit0 Hex=4, digit1 3, digit2 2, digit3 1; each digit's Anode low for 6 of 8 cycles.
REQ-031 Value=16'h0007, LZB=1 -> after Frame, only Anode[0] ever goes low; with DPIn=4'b0100, Anode[2] also goes low with DP=1.
REQ-032 Value changed mid-frame from 16'hAAAA to 16'h5555 -> Hex stays A until the Frame pulse, then 5 from next digit 0 onward.
REQ-033 Enable dropped for 10 cycles mid-digit 2 -> Anode=4'b1111, DigitSel=2 and count held; after re-enable, digit 2 completes its remaining cycles.
REQ-034 Reset asserted mid-digit 3 with Enable=1 -> next cycle all REQ-027 values, no Frame pulse.
REQ-035 Every cycle -> assertion that Anode has at most one 0 bit and Frame never high two consecutive cycles.

Source files
------------

// File: rtl/sseg_digit_scanner.sv
// sseg_digit_scanner
//   Time-multiplexes a four-digit common-anode 7-segment display.
//   A prescaler holds each digit for SCAN_DIV cycles. The first BLANK_CYC
//   cycles of every digit slot keep all anodes dark to suppress ghosting.
//   Value/DPIn are copied into shadow registers once per frame, so the
//   display only changes at frame boundaries. Leading zeros can be blanked.
//
// Ports
//   Clk       in   rising-edge clock
//   Reset     in   synchronous, active-high reset
//   Enable    in   1 = scan runs, 0 = scan frozen and display dark
//   Value     in   [15:0] four hex digits, [3:0] = digit 0 (rightmost)
//   DPIn      in   [3:0] decimal-point request, bit i for digit i
//   LZB       in   leading-zero blanking enable
//   Hex       out  [3:0] nibble of the selected digit (to segment decoder)
//   DP        out  decimal point of the selected digit (1 = lit)
//   Anode     out  [3:0] active-low digit enables
//   DigitSel  out  [1:0] index of the selected digit
//   Frame     out  one-cycle pulse in the cycle whose edge captures Value/DPIn
//
// Every output is a function of registers only. Enable and LZB are
// registered first, so each takes effect one cycle after it is sampled.
module sseg_digit_scanner #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [15:0] Value,
  input  logic [3:0]  DPIn,
  input  logic        LZB,
  output logic [3:0]  Hex,
  output logic        DP,
  output logic [3:0]  Anode,
  output logic [1:0]  DigitSel,
  output logic        Frame
);

  localparam int unsigned   CW    = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] count;
  logic [1:0]    digit;
  logic [15:0]   shadow_value;
  logic [3:0]    shadow_dp;
  logic          en_q;
  logic          lzb_q;
  logic          rst_q;
  logic          tick;
  logic [3:0]    blank;

  // en_q samples Enable even while Reset is high. Scanning therefore starts
  // on the first edge after release, and the scan keeps the frame timing
  // (count=0 in the first released cycle). rst_q keeps the anodes dark
  // during the post-reset cycle, even when BLANK_CYC is 0.
  always_ff @(posedge Clk) begin
    en_q  <= Enable;
    lzb_q <= LZB;
    rst_q <= Reset;
    if (Reset) begin
      count        <= '0;
      digit        <= '0;
      shadow_value <= '0;
      shadow_dp    <= '0;
    end else if (en_q) begin
      if (tick) begin
        count <= '0;
        digit <= digit + 2'd1;
        if (digit == 2'd3) begin
          shadow_value <= Value;
          shadow_dp    <= DPIn;
        end
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  always_comb begin
    tick = en_q && (count == LAST);
  end

  // A digit is a leading zero when it and every more significant digit
  // are zero, and it has no decimal point of its own.
  always_comb begin
    blank    = '0;
    blank[1] = lzb_q && (shadow_value[15:4]  == 12'h000) && !shadow_dp[1];
    blank[2] = lzb_q && (shadow_value[15:8]  == 8'h00)   && !shadow_dp[2];
    blank[3] = lzb_q && (shadow_value[15:12] == 4'h0)    && !shadow_dp[3];
  end

  always_comb begin
    Hex      = shadow_value[{digit, 2'b00} +: 4];
    DP       = shadow_dp[digit];
    DigitSel = digit;
    Frame    = tick && (digit == 2'd3);
    Anode    = '1;
    if (en_q && !rst_q && (count >= BLANK) && !blank[digit]) begin
      Anode[digit] = 1'b0;
    end
  end

endmodule
